// File: rtl/i2c_cfg_arbiter.sv
// i2c_cfg_arbiter
// Shares one I2C_Controller among NREQ configuration requesters. Requests are
// served round-robin; each granted 24-bit word {slave_addr, sub_addr, data} is
// driven through the controller's GO/END/ACK handshake. A NACK is re-issued up
// to MAX_RETRY times after a one-cycle GO-low gap. A transfer that spends
// TIMEOUT cycles waiting on the controller is aborted with an error and is not
// retried.
//
// Ports
//   iCLK       I2C control clock (the controller's CLOCK)
//   iRST       synchronous active-high reset
//   iREQ       per-requester request level, held until oDONE
//   iDATA      request words, requester i on [24i+23:24i]
//   oGNT       one-hot grant, held through the completion cycle
//   oDONE      one-cycle completion pulse to the granted requester
//   oERR       failure flag, meaningful only with oDONE
//   oBUSY      high whenever a transaction is in progress
//   oI2C_DATA  latched word for the controller
//   oI2C_GO    controller GO
//   iI2C_END   controller END (low while a transfer runs)
//   iI2C_ACK   controller ACK (1 = NACK)
module i2c_cfg_arbiter #(
   parameter int NREQ      = 2,
   parameter int MAX_RETRY = 3,
   parameter int TIMEOUT   = 1023
) (
   input  logic                iCLK,
   input  logic                iRST,
   input  logic [NREQ-1:0]     iREQ,
   input  logic [24*NREQ-1:0]  iDATA,
   output logic [NREQ-1:0]     oGNT,
   output logic [NREQ-1:0]     oDONE,
   output logic [NREQ-1:0]     oERR,
   output logic                oBUSY,
   output logic [23:0]         oI2C_DATA,
   output logic                oI2C_GO,
   input  logic                iI2C_END,
   input  logic                iI2C_ACK
);

   localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int RTW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int TW  = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_START,
      S_WAIT_END,
      S_GAP,
      S_RESP
   } state_t;

   state_t            state_q, state_d;
   logic [RRW-1:0]    rr_q, rr_d;
   logic [RRW-1:0]    gidx_q, gidx_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [23:0]       data_q, data_d;
   logic              go_q, go_d;
   logic              err_q, err_d;
   logic [RTW-1:0]    retry_q, retry_d;
   logic [TW-1:0]     timer_q, timer_d;

   // Round-robin pick: rotate the request vector so that bit 0 is the
   // requester at rr, take the lowest set bit, then rotate the offset back.
   logic [2*NREQ-1:0] req_dbl;
   logic [2*NREQ-1:0] req_rot;
   logic              pick_vld;
   logic [RRW:0]      pick_sum;
   logic [RRW-1:0]    pick_idx;
   logic [23:0]       pick_word;
   logic [RRW:0]      next_rr;
   logic [TW-1:0]     timer_inc;
   logic              timer_hit;

   always_comb begin
      req_dbl  = {iREQ, iREQ};
      req_rot  = req_dbl >> rr_q;
      pick_vld = 1'b0;
      pick_sum = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            pick_vld = 1'b1;
            pick_sum = {1'b0, rr_q} + (RRW+1)'(k);
         end
      end
      if (pick_sum >= (RRW+1)'(NREQ)) begin
         pick_sum = pick_sum - (RRW+1)'(NREQ);
      end
      pick_idx  = pick_sum[RRW-1:0];
      pick_word = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (pick_idx == RRW'(k)) begin
            pick_word = iDATA[24*k +: 24];
         end
      end
      next_rr = {1'b0, gidx_q} + (RRW+1)'(1);
      if (next_rr >= (RRW+1)'(NREQ)) begin
         next_rr = '0;
      end
      // The timer saturates at TIMEOUT; timer_hit marks the cycle whose
      // count brings the total to TIMEOUT.
      timer_inc = (timer_q == TW'(TIMEOUT)) ? timer_q : timer_q + TW'(1);
      timer_hit = (timer_q == TW'(TIMEOUT - 1));
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      gidx_d  = gidx_q;
      gnt_d   = gnt_q;
      data_d  = data_q;
      go_d    = go_q;
      err_d   = err_q;
      retry_d = retry_q;
      timer_d = timer_q;
      unique case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               gidx_d  = pick_idx;
               gnt_d   = NREQ'(1) << pick_idx;
               data_d  = pick_word;
               go_d    = 1'b1;
               err_d   = 1'b0;
               retry_d = '0;
               timer_d = '0;
               state_d = S_WAIT_START;
            end
         end
         S_WAIT_START: begin
            timer_d = timer_inc;
            if (!iI2C_END) begin
               state_d = S_WAIT_END;
            end else if (timer_hit) begin
               go_d    = 1'b0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_WAIT_END: begin
            timer_d = timer_inc;
            if (iI2C_END) begin
               go_d = 1'b0;
               if (!iI2C_ACK) begin
                  err_d   = 1'b0;
                  state_d = S_RESP;
               end else if (retry_q < RTW'(MAX_RETRY)) begin
                  retry_d = retry_q + RTW'(1);
                  state_d = S_GAP;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end
            end else if (timer_hit) begin
               // Timeouts go straight to the response; never retried.
               go_d    = 1'b0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_GAP: begin
            go_d    = 1'b1;
            timer_d = '0;
            state_d = S_WAIT_START;
         end
         S_RESP: begin
            gnt_d   = '0;
            rr_d    = next_rr[RRW-1:0];
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q <= S_IDLE;
         rr_q    <= '0;
         gidx_q  <= '0;
         gnt_q   <= '0;
         data_q  <= '0;
         go_q    <= 1'b0;
         err_q   <= 1'b0;
         retry_q <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         gidx_q  <= gidx_d;
         gnt_q   <= gnt_d;
         data_q  <= data_d;
         go_q    <= go_d;
         err_q   <= err_d;
         retry_q <= retry_d;
         timer_q <= timer_d;
      end
   end

   assign oGNT      = gnt_q;
   assign oDONE     = (state_q == S_RESP) ? gnt_q : '0;
   assign oERR      = (state_q == S_RESP && err_q) ? gnt_q : '0;
   assign oBUSY     = (state_q != S_IDLE);
   assign oI2C_DATA = data_q;
   assign oI2C_GO   = go_q;

endmodule
